// File: rtl/systolic_pkg.sv
// Shared constants and the drain state encoding for the systolic output drain engine.
package systolic_pkg;

    localparam int SOD_DATAWIDTH  = 32;
    localparam int SOD_N_SIZE     = 32;
    localparam int SOD_ADDR_WIDTH = 10;
    localparam int SOD_DEPTH      = 543;
    localparam int SOD_ROW_W      = SOD_DATAWIDTH * SOD_N_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry register FIFO; entry 0 is always the head so the output comes straight from a flop.
module drain_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [1:0]       count_q, count_d;

    // Next-state of the two entries; a pop on a full FIFO shifts entry 1 into the head.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    e0_d    = din;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    e0_d = din;
                end else if (push) begin
                    e1_d    = din;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop) begin
                    e0_d = e1_q;
                    if (push) begin
                        e1_d = din;
                    end else begin
                        count_d = 2'd1;
                    end
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/systolic_out_drain.sv
// Drain engine: walks the output buffer from address 0 and streams each row out through a skid FIFO.
module systolic_out_drain
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH_output = SOD_DATAWIDTH,
    parameter int N_SIZE           = SOD_N_SIZE,
    parameter int ADDR_WIDTH       = SOD_ADDR_WIDTH,
    parameter int DEPTH            = SOD_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH:0]                num_rows,
    output logic [ADDR_WIDTH-1:0]              rd_addr_outbuffer,
    input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data_outbuffer,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATAWIDTH_output*N_SIZE-1:0] m_data,
    output logic [ADDR_WIDTH-1:0]              m_row_idx,
    output logic                               m_last,
    output logic                               busy,
    output logic                               done
);

    localparam int                  ROW_W   = DATAWIDTH_output * N_SIZE;
    localparam int                  ENTRY_W = ROW_W + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    drain_state_e          state_q, state_d;
    logic [ADDR_WIDTH:0]   rows_q, rows_d;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [1:0]            fifo_count_s;
    logic [ENTRY_W-1:0]    fifo_head_s;
    logic [ENTRY_W-1:0]    fifo_din_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [2:0]            credit_s;

    // rd_addr_q always holds the last issued address, which is the row now returning when inflight_q is set.
    assign fifo_din_s = {rd_addr_q, rd_data_outbuffer};
    assign m_valid    = (fifo_count_s != 2'd0);
    assign pop_s      = m_valid && m_ready;
    assign credit_s   = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign issue_s    = (state_q == ST_DRAIN) && (issued_q < rows_q) && (credit_s < 3'd2);

    drain_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .count (fifo_count_s),
        .head  (fifo_head_s)
    );

    // Next-state for the FSM, counters and read-issue bookkeeping.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        inflight_d = 1'b0;
        rd_addr_d  = rd_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (issue_s) begin
            rd_addr_d  = issued_q[ADDR_WIDTH-1:0];
            issued_d   = issued_q + ONE_C;
            inflight_d = 1'b1;
        end else begin
            rd_addr_d  = rd_addr_q;
        end

        if (pop_s) begin
            accepted_d = accepted_q + ONE_C;
        end else begin
            accepted_d = accepted_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d     = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
                    issued_d   = '0;
                    accepted_d = '0;
                    if (num_rows == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_DRAIN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (issued_q == rows_q) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                // Look at the post-handshake count so done lands in the cycle right after the last beat.
                if (accepted_d == rows_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_addr_outbuffer = issue_s ? issued_q[ADDR_WIDTH-1:0] : rd_addr_q;
    assign m_data            = fifo_head_s[ROW_W-1:0];
    assign m_row_idx         = fifo_head_s[ENTRY_W-1:ROW_W];
    assign m_last            = m_valid && ({1'b0, m_row_idx} == (rows_q - ONE_C));
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_systolic_out_drain.sv
// Directed and randomized drains checked against an in-order row scoreboard with timing expectations.
module tb_systolic_out_drain;

    localparam int DW  = 32;
    localparam int NS  = 32;
    localparam int AW  = 10;
    localparam int DEP = 543;
    localparam int RW  = DW * NS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   num_rows;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [RW-1:0] m_data;
    logic [AW-1:0] m_row_idx;
    logic          m_last;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   salt   = 32'd0;

    systolic_out_drain #(
        .DATAWIDTH_output (DW),
        .N_SIZE           (NS),
        .ADDR_WIDTH       (AW),
        .DEPTH            (DEP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_rows          (num_rows),
        .rd_addr_outbuffer (rd_addr),
        .rd_data_outbuffer (rd_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_row_idx         (m_row_idx),
        .m_last            (m_last),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] row_val(input int r, input logic [31:0] s);
        logic [RW-1:0] v;
        for (int k = 0; k < NS; k++) begin
            v[k*DW +: DW] = 32'(r + 1) + s * 32'(k);
        end
        return v;
    endfunction

    // Output buffer model: synchronous read, one cycle of latency.
    always @(posedge clk) rd_data <= row_val(int'(rd_addr), salt);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    // mode 0: ready always, 1: pattern 1,0,0,1, 2: ready low for cycles 1..10, other: random
    task automatic run_drain(input int n, input int mode, input bit glitch);
        int            rows_exp;
        int            exp_idx;
        int            issued_seen;
        int            exp_done;
        int            post;
        bit            fin;
        bit            stalled;
        bit            hs;
        logic [RW-1:0] prev_data;
        logic [AW-1:0] prev_idx;
        rows_exp    = (n > DEP) ? DEP : n;
        exp_idx     = 0;
        issued_seen = 0;
        post        = 0;
        fin         = 1'b0;
        stalled     = 1'b0;
        prev_data   = '0;
        prev_idx    = '0;
        exp_done    = (rows_exp == 0) ? 1 : (mode == 0) ? rows_exp + 3 : (mode == 2) ? rows_exp + 11 : -1;
        @(negedge clk);
        start    = 1'b1;
        num_rows = (AW + 1)'(n);
        m_ready  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 8 * rows_exp + 64 && post < 3; cyc++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       m_ready = (cyc > 10);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = glitch && (cyc == 5);
            if (start) num_rows = 11'd3;
            #1;
            if (cyc == 1) begin
                check("busy_c1", 64'(busy), 64'(rows_exp != 0));
                if (rows_exp != 0) check("addr_c1", 64'(rd_addr), 64'd0);
            end
            if (mode == 2 && cyc == 10) begin
                check("stall_addr", 64'(rd_addr), 64'd1);
                check("stall_head", 64'(m_row_idx), 64'd0);
            end
            if (stalled) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_idx", 64'(m_row_idx), 64'(prev_idx));
                check_row("stall_data", m_data, prev_data);
            end
            hs = m_valid && m_ready;
            if (fin) begin
                post++;
                check("post_done", 64'(done), 64'd0);
                check("post_valid", 64'(m_valid), 64'd0);
                check("post_busy", 64'(busy), 64'd0);
            end else begin
                if (hs) begin
                    check("row_idx", 64'(m_row_idx), 64'(exp_idx));
                    check("row_last", 64'(m_last), 64'(exp_idx == rows_exp - 1));
                    check_row("row_data", m_data, row_val(exp_idx, salt));
                    if (mode == 0) check("beat_cycle", 64'(cyc), 64'(exp_idx + 3));
                    exp_idx++;
                end
                if (busy) begin
                    if (int'(rd_addr) + 1 > issued_seen) issued_seen = int'(rd_addr) + 1;
                    check("outstanding", 64'(issued_seen - exp_idx <= 2), 64'd1);
                end
                if (done) begin
                    fin = 1'b1;
                    check("done_beats", 64'(exp_idx), 64'(rows_exp));
                    check("done_busy", 64'(busy), 64'd0);
                    check("done_valid", 64'(m_valid), 64'd0);
                    if (exp_done > 0) check("done_cycle", 64'(cyc), 64'(exp_done));
                end else if (rows_exp != 0) begin
                    check("busy_run", 64'(busy), 64'd1);
                end else begin
                    check("zero_valid", 64'(m_valid), 64'd0);
                end
            end
            stalled   = m_valid && !m_ready;
            prev_data = m_data;
            prev_idx  = m_row_idx;
            @(negedge clk);
        end
        check("finished", 64'(fin), 64'd1);
        m_ready = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_idx"}, 64'(m_row_idx), 64'd0);
        check({tag, "_last"}, 64'(m_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check_row({tag, "_data"}, m_data, '0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        num_rows = '0;
        m_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        salt = 32'd0;
        run_drain(4, 0, 1'b0);
        salt = $urandom;
        run_drain(8, 1, 1'b0);
        salt = $urandom;
        run_drain(20, 2, 1'b0);
        run_drain(0, 0, 1'b0);
        salt = $urandom;
        run_drain(600, 0, 1'b0);
        salt = $urandom;
        run_drain(16, 0, 1'b1);

        // Abort a 16-row drain after three accepted beats.
        salt = $urandom;
        @(negedge clk);
        start    = 1'b1;
        num_rows = 11'd16;
        m_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_abort_idx", 64'(m_row_idx), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_drain(2, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            salt = $urandom;
            run_drain(int'($urandom_range(1, 40)), 3, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_out_drain.md
# systolic_out_drain

Read-side drain engine for the systolic output buffer. After a final tile has been written, it walks the output buffer's read port from address 0 upward and issues synchronous reads. Each returned N_SIZE×DATAWIDTH_output row goes onto a valid/ready stream toward the post-processing and writeback path. A 2-entry skid FIFO absorbs the one-cycle read latency, so downstream backpressure never loses or duplicates a row.

## Interface
- DATAWIDTH_output, 32, width of one accumulator lane
- N_SIZE, 32, lanes per row
- ADDR_WIDTH, 10, output-buffer address width
- DEPTH, 543, output-buffer depth in rows; maximum drain length
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a drain; sampled only in IDLE
- num_rows  input  ADDR_WIDTH+1  number of rows to drain; sampled with start
- rd_addr_outbuffer  output  ADDR_WIDTH  output-buffer read address
- rd_data_outbuffer  input  DATAWIDTH_output*N_SIZE  read data, valid exactly one cycle after the address
- m_valid  output  1  stream row valid
- m_ready  input  1  downstream accepts the row
- m_data  output  DATAWIDTH_output*N_SIZE  row data; lane k is at bits k*DATAWIDTH_output +: DATAWIDTH_output
- m_row_idx  output  ADDR_WIDTH  buffer address the row was read from
- m_last  output  1  high on the final row of the drain
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last row is accepted

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE → DRAIN when start=1. On this transition:
  - num_rows is latched, saturated to DEPTH.
  - The issue counter and the accept counter are cleared.
- IDLE → DONE when start=1 and num_rows=0. No read is issued and no beat is produced.
- A start seen outside IDLE is ignored. It has no side effects.
- Read issue in DRAIN, per cycle: issue when issued < rows and (fifo_count + inflight − pop) < 2.
  - pop = m_valid & m_ready.
  - On issue: rd_addr_outbuffer = issued, then issued increments, and inflight is set for the next cycle.
- Capture: when inflight=1, rd_data_outbuffer and its address are pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- rd_addr_outbuffer holds its last value when no read is issued. The buffer read has no enable, so extra reads are harmless.
- DRAIN → FLUSH when issued == rows.
- FLUSH → DONE when the accept counter reaches rows, i.e. the last beat has been accepted.
- DONE lasts one cycle (done=1), then goes to IDLE.
- m_last = (m_row_idx == rows−1) & m_valid.
- m_data and m_row_idx are stable while m_valid=1 and m_ready=0.
- Rows are emitted in strictly increasing address order. None is skipped or repeated.
- Reset values: rd_addr_outbuffer=0, m_valid=0, m_data=0, m_row_idx=0, m_last=0, busy=0, done=0, FIFO empty, state IDLE.
- Reset asserted mid-drain aborts immediately:
  - No done pulse is produced.
  - Any in-flight read data is discarded.

## Timing
- Cycle 0: start sampled.
- Cycle 1: state DRAIN, busy=1, rd_addr_outbuffer=0.
- Cycle 2: rd_data row 0 presented on rd_data_outbuffer.
- Cycle 3: m_valid=1 with row 0.
- With m_ready held at 1, throughput is one row per cycle. The last row appears at cycle rows+2.
- done pulses in the cycle after the last handshake; busy drops in that same cycle.
- With num_rows=0: done=1 in cycle 1, busy stays 0, m_valid never rises.
- m_valid does not depend combinationally on m_ready. m_data comes from a register (the FIFO head).

## Structure
- Shared constants belong in systolic_pkg:
  - the row-width localparam (DATAWIDTH_output*N_SIZE);
  - the drain state enum typedef.
- Sub-module drain_skid_fifo: 2-entry register FIFO.
  - Width: row + ADDR_WIDTH.
  - Ports: push, pop, count, head; simultaneous push/pop is allowed.
- The top level holds the FSM, the counters, and the credit logic.

## Test plan
- Basic drain: num_rows=4, model buffer row r = {N_SIZE{r+1}}, m_ready=1 → 4 beats with m_row_idx 0..3 in cycles 3..6, m_last only on idx 3, done in cycle 7.
- Backpressure: num_rows=8, m_ready toggling 1,0,0,1 → exactly 8 beats in order, data stable during stalls, at most 2 reads outstanding beyond acceptance.
- Stall during issue: hold m_ready=0 for 10 cycles after start → FIFO holds rows 0–1, rd_addr_outbuffer stops at 1; release → rows 0..N follow with no gap or duplicate.
- Edge lengths: num_rows=0 → done in cycle 1 with no beats; num_rows=600 → saturates to 543 beats, last m_row_idx=542.
- start while busy: pulse start at cycle 5 of a 16-row drain → ignored; exactly 16 beats and one done.
- Reset mid-operation: assert rst_n=0 after 3 accepted beats → all outputs at reset values asynchronously; a new start with 2 rows drains rows 0..1 cleanly.
